// File: rtl/tdisk_pkg.sv
// Shared TimeDisk definitions: op codes, status codes and the block-mover FSM states.
package tdisk_pkg;

   localparam int AW_DEF = 20;

   localparam logic OP_FILL = 1'b0;
   localparam logic OP_COPY = 1'b1;

   typedef enum logic [1:0] {
      STAT_NONE  = 2'b00,
      STAT_OK    = 2'b01,
      STAT_ABORT = 2'b10,
      STAT_ZERO  = 2'b11
   } stat_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_RSETUP,
      S_RSTB,
      S_WAIT2,
      S_WSETUP,
      S_WSTB,
      S_DONE
   } state_t;

   // States in which the mover owns the SRAM pins.
   function automatic logic is_access(input state_t s);
      return (s == S_RSETUP) || (s == S_RSTB) || (s == S_WSETUP) || (s == S_WSTB);
   endfunction

endpackage

// File: rtl/rbm_access_timer.sv
// Times one SRAM access (SETUP plus STB strobe cycles) and flags the final strobe cycle.
module rbm_access_timer #(
   parameter int STB = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic last
);

   logic [2:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = run ? cnt_q + 3'd1 : 3'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // cnt 0 is the SETUP cycle, 1..STB are the strobe cycles.
   assign last = run && (cnt_q == 3'(STB));

endmodule

// File: rtl/ram_block_mover.sv
// Background SRAM FILL/COPY sequencer; only touches the SRAM inside parent-granted idle windows.
module ram_block_mover
   import tdisk_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int LW  = 16,
   parameter int STB = 1
) (
   input  logic          C7M,
   input  logic          RES,
   input  logic          BGWIN,
   input  logic          CMD_VALID,
   output logic          CMD_READY,
   input  logic          CMD_OP,
   input  logic [AW-1:0] CMD_SRC,
   input  logic [AW-1:0] CMD_DST,
   input  logic [LW-1:0] CMD_LEN,
   input  logic [7:0]    CMD_FILL,
   input  logic          ABORT,
   output logic          GNT,
   output logic [AW-1:0] RADDR,
   output logic [7:0]    RDOUT,
   input  logic [7:0]    RDIN,
   output logic          RCS,
   output logic          RWE,
   output logic          BUSY,
   output logic          DONE,
   output logic [1:0]    STAT
);

   state_t        state_q, state_d;
   logic          op_q, op_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [7:0]    fill_q, fill_d;
   logic [7:0]    buf_q, buf_d;
   stat_t         stat_q, stat_d;
   logic          gnt_q, gnt_d;
   logic          rcs_q, rcs_d;
   logic          rwe_q, rwe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [AW-1:0] raddr_q, raddr_d;
   logic [7:0]    rdout_q, rdout_d;
   logic          acc_last;

   rbm_access_timer #(.STB(STB)) u_timer (
      .clk  (C7M),
      .rst  (RES),
      .run  (is_access(state_q)),
      .last (acc_last)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      fill_d  = fill_q;
      buf_d   = buf_q;
      stat_d  = stat_q;

      case (state_q)
         S_IDLE: begin
            if (CMD_VALID) begin
               state_d = S_LOAD;
               op_d    = CMD_OP;
               src_d   = CMD_SRC;
               dst_d   = CMD_DST;
               rem_d   = CMD_LEN;
               fill_d  = CMD_FILL;
               stat_d  = STAT_NONE;
            end
         end
         S_LOAD: begin
            if (rem_q == '0) begin
               state_d = S_DONE;
               stat_d  = STAT_ZERO;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ABORT) begin
               state_d = S_DONE;
               stat_d  = STAT_ABORT;
            end else if (BGWIN) begin
               state_d = (op_q == OP_COPY) ? S_RSETUP : S_WSETUP;
            end
         end
         S_RSETUP: state_d = S_RSTB;
         S_RSTB: begin
            if (acc_last) begin
               buf_d   = RDIN;
               src_d   = src_q + AW'(1);
               state_d = S_WAIT2;
            end
         end
         S_WAIT2: begin
            // An abort here drops the byte already sitting in buf_q.
            if (ABORT) begin
               state_d = S_DONE;
               stat_d  = STAT_ABORT;
            end else if (BGWIN) begin
               state_d = S_WSETUP;
            end
         end
         S_WSETUP: state_d = S_WSTB;
         S_WSTB: begin
            if (acc_last) begin
               dst_d = dst_q + AW'(1);
               rem_d = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  state_d = S_DONE;
                  stat_d  = STAT_OK;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so pins change cleanly on the clock.
      gnt_d   = is_access(state_d);
      rcs_d   = (state_d == S_RSTB) || (state_d == S_WSTB);
      rwe_d   = (state_d == S_WSTB);
      busy_d  = !((state_d == S_IDLE) || (state_d == S_DONE));
      done_d  = (state_d == S_DONE);
      raddr_d = raddr_q;
      rdout_d = rdout_q;
      if (state_d == S_RSETUP) begin
         raddr_d = src_q;
      end else if (state_d == S_WSETUP) begin
         raddr_d = dst_q;
         rdout_d = (op_q == OP_COPY) ? buf_q : fill_q;
      end
   end

   always_ff @(posedge C7M or posedge RES) begin
      if (RES) begin
         state_q <= S_IDLE;
         op_q    <= OP_FILL;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         fill_q  <= '0;
         buf_q   <= '0;
         stat_q  <= STAT_NONE;
         gnt_q   <= 1'b0;
         rcs_q   <= 1'b0;
         rwe_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         raddr_q <= '0;
         rdout_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         fill_q  <= fill_d;
         buf_q   <= buf_d;
         stat_q  <= stat_d;
         gnt_q   <= gnt_d;
         rcs_q   <= rcs_d;
         rwe_q   <= rwe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         raddr_q <= raddr_d;
         rdout_q <= rdout_d;
      end
   end

   assign CMD_READY = CMD_VALID && (state_q == S_IDLE);
   assign GNT       = gnt_q;
   assign RCS       = rcs_q;
   assign RWE       = rwe_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign RADDR     = raddr_q;
   assign RDOUT     = rdout_q;
   assign STAT      = stat_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// Scoreboard bench: a byte-array model predicts every SRAM read/write and each DONE status.
module tb_ram_block_mover;

   localparam int AW   = 20;
   localparam int LW   = 16;
   localparam int STB  = 2;
   localparam int MASK = (1 << AW) - 1;

   logic          C7M = 1'b0;
   logic          RES = 1'b1;
   logic          BGWIN = 1'b0;
   logic          CMD_VALID = 1'b0;
   logic          CMD_READY;
   logic          CMD_OP = 1'b0;
   logic [AW-1:0] CMD_SRC = '0;
   logic [AW-1:0] CMD_DST = '0;
   logic [LW-1:0] CMD_LEN = '0;
   logic [7:0]    CMD_FILL = '0;
   logic          ABORT = 1'b0;
   logic          GNT, RCS, RWE, BUSY, DONE;
   logic [AW-1:0] RADDR;
   logic [7:0]    RDOUT, RDIN;
   logic [1:0]    STAT;

   logic [7:0] sram  [0:(1<<AW)-1];
   logic [7:0] model [0:(1<<AW)-1];

   typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
   typedef struct { logic [1:0] st; bit zero; time acc; } dn_t;
   wr_t           wq[$];
   logic [AW-1:0] rq[$];
   dn_t           dq[$];

   int chk = 0;
   int fail = 0;
   int done_cnt = 0;
   int bg_mode = 0;
   int ph = 0;
   bit gnt_p = 0, rcs_p = 0, rwe_p = 0, bg_p = 0;
   int run = 0;

   ram_block_mover #(.AW(AW), .LW(LW), .STB(STB)) dut (
      .C7M(C7M), .RES(RES), .BGWIN(BGWIN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_OP(CMD_OP), .CMD_SRC(CMD_SRC), .CMD_DST(CMD_DST), .CMD_LEN(CMD_LEN),
      .CMD_FILL(CMD_FILL), .ABORT(ABORT), .GNT(GNT), .RADDR(RADDR), .RDOUT(RDOUT),
      .RDIN(RDIN), .RCS(RCS), .RWE(RWE), .BUSY(BUSY), .DONE(DONE), .STAT(STAT)
   );

   always #5 C7M = ~C7M;

   assign RDIN = (RCS && !RWE) ? sram[RADDR] : 8'h00;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm);
      chk++;
      fail++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   // Parent window generator.
   initial forever begin
      @(posedge C7M); #1;
      case (bg_mode)
         0: BGWIN = 1'b1;
         1: begin BGWIN = (ph == 0); ph = (ph + 1) % 4; end
         default: BGWIN = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: pops expectations whenever the DUT starts an access or pulses DONE.
   always @(negedge C7M) begin
      if (RES) begin
         gnt_p = 0; rcs_p = 0; rwe_p = 0; bg_p = 0; run = 0;
      end else begin
         if (RWE) check("rwe_needs_rcs", RCS, 1);
         if (RCS) check("rcs_needs_gnt", GNT, 1);
         if (GNT && !gnt_p) check("gnt_in_window", bg_p, 1);
         if (RCS) run++;
         else if (rcs_p) begin check("strobe_len", run, STB); run = 0; end
         if (RCS && !rcs_p) begin
            if (RWE) begin
               if (wq.size() == 0) flag("unexpected_write");
               else begin
                  wr_t w;
                  w = wq.pop_front();
                  check("wr_addr", RADDR, w.a);
                  check("wr_data", RDOUT, w.d);
               end
               sram[RADDR] = RDOUT;
            end else begin
               if (rq.size() == 0) flag("unexpected_read");
               else check("rd_addr", RADDR, rq.pop_front());
            end
         end
         if (DONE) begin
            done_cnt++;
            check("done_busy", BUSY, 0);
            check("done_ready", CMD_READY, 0);
            if (dq.size() == 0) flag("unexpected_done");
            else begin
               dn_t e;
               e = dq.pop_front();
               check("stat", STAT, e.st);
               if (e.zero) check("zero_len_latency", 32'(($time - e.acc) / 10), 2);
               else if (e.st == 2'b01) check("done_after_wstb", rwe_p, 1);
            end
         end
         gnt_p = GNT; rcs_p = RCS; rwe_p = RWE; bg_p = BGWIN;
      end
   end

   // Predict the command from the byte-serial rules; nwr < len models an abort.
   task automatic issue(input bit op, input int src, input int dst, input int len,
                        input logic [7:0] fv, input int nwr, input logic [1:0] st,
                        input bit hold_busy);
      int a, d, n;
      logic [7:0] v;
      wr_t w;
      dn_t e;
      for (int i = 0; i < len; i++) begin
         a = (src + i) & MASK;
         d = (dst + i) & MASK;
         if (i < nwr) begin
            if (op) begin rq.push_back(AW'(a)); v = model[a]; end
            else v = fv;
            model[d] = v;
            w.a = AW'(d); w.d = v;
            wq.push_back(w);
         end else if (i == nwr && op) begin
            rq.push_back(AW'(a));
         end
      end
      CMD_OP = op; CMD_SRC = AW'(src); CMD_DST = AW'(dst); CMD_LEN = LW'(len); CMD_FILL = fv;
      CMD_VALID = 1'b1;
      n = 0;
      do begin @(negedge C7M); n++; end while (!CMD_READY && n < 200);
      if (!CMD_READY) flag("accept_timeout");
      e.st = st; e.zero = (len == 0); e.acc = $time;
      dq.push_back(e);
      @(posedge C7M); #1;
      if (hold_busy) begin
         @(negedge C7M);
         check("ready_while_busy", CMD_READY, 0);
         check("busy_in_load", BUSY, 1);
         @(posedge C7M); #1;
      end
      CMD_VALID = 1'b0;
   endtask

   task automatic wait_done(input int start);
      int n;
      n = 0;
      while (done_cnt == start && n < 3000) begin @(negedge C7M); #1; n++; end
      if (done_cnt == start) begin
         flag("done_timeout");
         wq.delete(); rq.delete(); dq.delete();
      end
   endtask

   initial begin
      int dc, op, src, dst, len, n;
      bit rp;
      for (int i = 0; i <= MASK; i++) begin
         sram[i] = 8'($urandom);
         model[i] = sram[i];
      end
      sram[32'h200] = 8'h11; sram[32'h201] = 8'h22; sram[32'h202] = 8'h33;
      model[32'h200] = 8'h11; model[32'h201] = 8'h22; model[32'h202] = 8'h33;

      repeat (3) @(posedge C7M);
      @(negedge C7M);
      check("rst_gnt", GNT, 0); check("rst_rcs", RCS, 0); check("rst_rwe", RWE, 0);
      check("rst_busy", BUSY, 0); check("rst_done", DONE, 0); check("rst_raddr", RADDR, 0);
      check("rst_rdout", RDOUT, 0); check("rst_stat", STAT, 0);
      @(posedge C7M); #1; RES = 1'b0;

      // FILL with window always open.
      bg_mode = 0; dc = done_cnt;
      issue(0, 0, 32'h100, 4, 8'hA5, 4, 2'b01, 0);
      wait_done(dc);

      // COPY with sparse windows.
      bg_mode = 1; dc = done_cnt;
      issue(1, 32'h200, 32'h300, 3, 8'h00, 3, 2'b01, 0);
      wait_done(dc);
      check("copy_mem0", sram[32'h300], 8'h11);
      check("copy_mem1", sram[32'h301], 8'h22);
      check("copy_mem2", sram[32'h302], 8'h33);

      // FILL across the top of the address space.
      bg_mode = 2; dc = done_cnt;
      issue(0, 0, 32'hFFFFE, 3, 8'h5C, 3, 2'b01, 0);
      wait_done(dc);

      // Zero-length command, with a second offer while busy.
      dc = done_cnt;
      issue(1, 32'h10, 32'h20, 0, 8'h00, 0, 2'b11, 1);
      wait_done(dc);

      // Overlapping forward copy replicates the first byte.
      bg_mode = 0; dc = done_cnt;
      issue(1, 32'h800, 32'h801, 4, 8'h00, 4, 2'b01, 0);
      wait_done(dc);
      check("overlap_mem", sram[32'h804], sram[32'h800]);

      // Abort raised during the second read of a 5-byte copy.
      dc = done_cnt;
      issue(1, 32'h400, 32'h500, 5, 8'h00, 1, 2'b10, 0);
      n = 0; dst = 0; rp = 0;
      while (dst < 2 && n < 500) begin
         @(negedge C7M); n++;
         if (RCS && !RWE && !rp) dst++;
         rp = RCS && !RWE;
      end
      if (dst < 2) flag("abort_read_timeout");
      ABORT = 1'b1;
      wait_done(dc);
      ABORT = 1'b0;

      // Randomised commands.
      for (int k = 0; k < 14; k++) begin
         op  = int'($urandom_range(0, 1));
         src = ($urandom_range(0, 1) == 1) ? int'($urandom) & MASK : MASK - int'($urandom_range(0, 3));
         dst = ($urandom_range(0, 1) == 1) ? int'($urandom) & MASK : MASK - int'($urandom_range(0, 3));
         len = int'($urandom_range(0, 6));
         bg_mode = int'($urandom_range(0, 2));
         dc = done_cnt;
         issue(op[0], src, dst, len, 8'($urandom), len, (len == 0) ? 2'b11 : 2'b01, 0);
         wait_done(dc);
      end

      // Reset in the middle of a write strobe.
      bg_mode = 0;
      issue(0, 0, 32'h700, 3, 8'h3C, 3, 2'b01, 0);
      n = 0;
      do begin @(negedge C7M); n++; end while (!(RCS && RWE) && n < 200);
      if (!(RCS && RWE)) flag("wstb_timeout");
      #2 RES = 1'b1;
      #1;
      check("async_rcs", RCS, 0); check("async_rwe", RWE, 0);
      check("async_gnt", GNT, 0); check("async_busy", BUSY, 0);
      wq.delete(); rq.delete(); dq.delete();
      repeat (2) @(posedge C7M);
      #1 RES = 1'b0;
      @(negedge C7M);
      check("post_rst_stat", STAT, 0);
      check("post_rst_busy", BUSY, 0);
      model = sram;
      @(posedge C7M); #1;
      dc = done_cnt;
      issue(0, 0, 32'h710, 2, 8'h99, 2, 2'b01, 0);
      wait_done(dc);

      repeat (3) @(negedge C7M);
      check("wq_drained", wq.size(), 0);
      check("rq_drained", rq.size(), 0);
      check("dq_drained", dq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", chk, fail);
      $finish;
   end

endmodule
